// File: rtl/store_controller.sv
// Store sequencer: turns one CPU store into one or two aligned req/ack write beats on the data-memory port.
// Build option: define STORE_SPLIT_EN to let misaligned stores proceed as split beats instead of being rejected.
`timescale 1ns/1ps
module store_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [1:0]  I_storesel,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  output logic        O_mem_req,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_wdata,
  output logic [3:0]  O_mem_be,
  input  logic        I_mem_ack,
  output logic        O_done,
  output logic        O_misaligned,
  output logic        O_bus_err
);

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_be;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_bus_err;

  state_t        w_state_nxt;
  logic [31:0]   w_addr_nxt;
  logic [31:0]   w_wdata_nxt;
  logic [3:0]    w_be_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done_nxt;
  logic          w_bus_err_nxt;
  logic          w_finish;

  logic [3:0]    w_mask;
  logic [31:0]   w_data_m;
  logic [31:0]   w_lo_d;
  logic [3:0]    w_lo_be;

`ifdef STORE_SPLIT_EN
  logic [31:0]   r_hi_wdata;
  logic [3:0]    r_hi_be;
  logic [31:0]   w_hi_d;
  logic [3:0]    w_hi_be;
  logic [31:0]   w_hi_wdata_nxt;
  logic [3:0]    w_hi_be_nxt;
`else
  logic          r_misal;
  logic          w_misal_nxt;
  logic          w_misaligned;
`endif

  // Lane placement: mask the data to its size first so unused lanes stay 0 after the shift.
  always_comb begin
    unique case (I_storesel)
      STORE_SB: w_mask = 4'b0001;
      STORE_SH: w_mask = 4'b0011;
      STORE_SW: w_mask = 4'b1111;
      default:  w_mask = 4'b1111;
    endcase
    w_data_m = I_data & {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
`ifdef STORE_SPLIT_EN
    {w_hi_d, w_lo_d}   = {32'b0, w_data_m} << {I_addr[1:0], 3'b000};
    {w_hi_be, w_lo_be} = {4'b0, w_mask} << I_addr[1:0];
`else
    w_lo_d  = w_data_m << {I_addr[1:0], 3'b000};
    w_lo_be = w_mask << I_addr[1:0];
    if (I_storesel == STORE_SB)      w_misaligned = 1'b0;
    else if (I_storesel == STORE_SH) w_misaligned = I_addr[0];
    else                             w_misaligned = |I_addr[1:0];
`endif
  end

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_mem_addr;
    w_wdata_nxt   = r_mem_wdata;
    w_be_nxt      = r_mem_be;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = 1'b0;
    w_bus_err_nxt = 1'b0;
    w_finish      = 1'b0;
`ifdef STORE_SPLIT_EN
    w_hi_wdata_nxt = r_hi_wdata;
    w_hi_be_nxt    = r_hi_be;
`else
    w_misal_nxt    = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (I_valid) begin
`ifndef STORE_SPLIT_EN
          if (w_misaligned) begin
            w_misal_nxt = 1'b1;
          end else begin
`else
          begin
            w_hi_wdata_nxt = w_hi_d;
            w_hi_be_nxt    = w_hi_be;
`endif
            w_state_nxt = S_BEAT0;
            w_addr_nxt  = {I_addr[31:2], 2'b00};
            w_wdata_nxt = w_lo_d;
            w_be_nxt    = w_lo_be;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        if (I_mem_ack) begin
`ifdef STORE_SPLIT_EN
          if (r_state == S_BEAT0 && r_hi_be != 4'b0000) begin
            w_state_nxt = S_BEAT1;
            w_addr_nxt  = r_mem_addr + 32'd4;
            w_wdata_nxt = r_hi_wdata;
            w_be_nxt    = r_hi_be;
            w_cnt_nxt   = '0;
          end else begin
`else
          begin
`endif
            w_finish   = 1'b1;
            w_done_nxt = 1'b1;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Timeout abandons the whole store, including any pending second beat.
          w_finish      = 1'b1;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_finish) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
          w_wdata_nxt = '0;
          w_be_nxt    = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_bus_err   <= 1'b0;
`ifdef STORE_SPLIT_EN
      r_hi_wdata  <= '0;
      r_hi_be     <= '0;
`else
      r_misal     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_mem_be    <= w_be_nxt;
      r_cnt       <= w_cnt_nxt;
      r_done      <= w_done_nxt;
      r_bus_err   <= w_bus_err_nxt;
`ifdef STORE_SPLIT_EN
      r_hi_wdata  <= w_hi_wdata_nxt;
      r_hi_be     <= w_hi_be_nxt;
`else
      r_misal     <= w_misal_nxt;
`endif
    end
  end

  assign O_ready     = (r_state == S_IDLE);
  assign O_mem_req   = (r_state != S_IDLE);
  assign O_mem_addr  = r_mem_addr;
  assign O_mem_wdata = r_mem_wdata;
  assign O_mem_be    = r_mem_be;
  assign O_done      = r_done;
  assign O_bus_err   = r_bus_err;
`ifdef STORE_SPLIT_EN
  assign O_misaligned = 1'b0;
`else
  assign O_misaligned = r_misal;
`endif

endmodule

// File: tb/tb_store_controller.sv
// Randomized scoreboard bench for store_controller; the byte-level reference model follows the STORE_SPLIT_EN build option.
`timescale 1ns/1ps
module tb_store_controller;

  localparam int TO    = 4;
  localparam int NEVER = 1000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  typedef struct {
    int code;  // 1 done, 2 misaligned, 3 bus error
    int cyc;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [1:0]  storesel;
  logic [31:0] addr;
  logic [31:0] data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        misal;
  logic        bus_err;

  beat_t exp_beats[$];
  evt_t  exp_evt[$];
  int    ack_waits[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  store_controller #(.TIMEOUT(TO)) dut (
    .I_clk        (clk),
    .I_rst        (rst_n),
    .I_valid      (valid),
    .O_ready      (ready),
    .I_storesel   (storesel),
    .I_addr       (addr),
    .I_data       (data),
    .O_mem_req    (mem_req),
    .O_mem_addr   (mem_addr),
    .O_mem_wdata  (mem_wdata),
    .O_mem_be     (mem_be),
    .I_mem_ack    (mem_ack),
    .O_done       (done),
    .O_misaligned (misal),
    .O_bus_err    (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ack responder: each beat is acked after the number of wait cycles queued for it.
  initial begin
    int  bc;
    int  w;
    bit  active;
    bc = 0; w = 0; active = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) active = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!active) begin
          active = 1;
          bc = 0;
          w = (ack_waits.size() != 0) ? ack_waits.pop_front() : 0;
        end
        if (bc == w) mem_ack = 1'b1;
        bc++;
      end else begin
        active = 0;
        mem_ack = ($urandom_range(0, 3) == 0);  // stray acks while idle must be ignored
      end
    end
  end

  // Monitor: checks every request cycle against the expected beat and every pulse against the expected event.
  initial begin
    bit    prev_req;
    bit    prev_ack;
    bit    have;
    beat_t cur;
    evt_t  e;
    int    code;
    prev_req = 0; prev_ack = 0; have = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0;
        prev_ack = 0;
        have = 0;
      end else begin
        if (mem_req) begin
          if (!prev_req || prev_ack) begin
            if (exp_beats.size() == 0) begin
              total++; bad++; have = 0;
              $display("FAIL unexpected_beat: got addr %h with no beat expected", mem_addr);
            end else begin
              cur = exp_beats.pop_front();
              have = 1;
            end
          end
          if (have) begin
            check("beat_addr", mem_addr, cur.addr);
            check("beat_wdata", mem_wdata, cur.wdata);
            check("beat_be", {28'b0, mem_be}, {28'b0, cur.be});
          end
        end
        if (done || misal || bus_err) begin
          code = done ? 1 : (misal ? 2 : 3);
          check("single_pulse", 32'(int'(done) + int'(misal) + int'(bus_err)), 32'd1);
          if (exp_evt.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_event: got code %0d with none expected", code);
          end else begin
            e = exp_evt.pop_front();
            check("event_code", 32'(code), 32'(e.code));
            check("event_cycle", 32'(cyc), 32'(e.cyc));
            check("beats_left", 32'(exp_beats.size()), 32'd0);
          end
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
      end
    end
  end

  // Reference model: place each byte at its own byte address, group by word, then schedule the beats.
  task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                       input int w0, input int w1, input bit want_evt);
    beat_t       bt[2];
    int          w[2];
    int          n, nb, nocc, lat, code, lane, k, acc, t;
    logic [31:0] base, ba;
    bit          split;
`ifdef STORE_SPLIT_EN
    split = 1;
`else
    split = 0;
`endif
    w[0] = w0; w[1] = w1;
    n = (sel == 2'd0) ? 1 : ((sel == 2'd1) ? 2 : 4);
    base = {a[31:2], 2'b00};
    bt[0] = '{addr: base, wdata: 32'h0, be: 4'h0};
    bt[1] = '{addr: base + 32'd4, wdata: 32'h0, be: 4'h0};
    if ((a % n) != 0 && !split) begin
      nb = 0;
    end else begin
      nb = 1;
      for (int i = 0; i < n; i++) begin
        ba = a + 32'(i);
        k = (ba[31:2] == base[31:2]) ? 0 : 1;
        if (k == 1) nb = 2;
        lane = int'(ba[1:0]);
        bt[k].wdata[8*lane +: 8] = d[8*i +: 8];
        bt[k].be[lane] = 1'b1;
      end
    end
    lat = 0; nocc = 0; code = (nb == 0) ? 2 : 1;
    for (int j = 0; j < nb; j++) begin
      nocc++;
      if (w[j] >= TO) begin
        lat += TO;
        code = 3;
        break;
      end
      lat += w[j] + 1;
    end

    @(posedge clk);
    #1;
    check("ready_before_issue", {31'b0, ready}, 32'd1);
    acc = cyc + 1;
    for (int j = 0; j < nocc; j++) begin
      exp_beats.push_back(bt[j]);
      ack_waits.push_back(w[j]);
    end
    // Event becomes visible after the edge that ends the last beat (accept edge + lat).
    if (want_evt) exp_evt.push_back('{code: code, cyc: acc + lat});
    valid = 1'b1; storesel = sel; addr = a; data = d;
    @(posedge clk);
    #1;
    valid = 1'b0; storesel = 2'($urandom); addr = $urandom; data = $urandom;
    if (want_evt) begin
      t = 0;
      while (exp_evt.size() != 0 && t < 300) begin
        @(posedge clk);
        t++;
      end
      check("event_arrived", 32'(exp_evt.size()), 32'd0);
      #1;
      check("ready_after", {31'b0, ready}, 32'd1);
      check("req_after", {31'b0, mem_req}, 32'd0);
      exp_evt.delete();
      exp_beats.delete();
      ack_waits.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sel;
    logic [31:0] a;
    int          n;
    rst_n = 1'b0; valid = 1'b0; storesel = 2'b00; addr = 32'h0; data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_pulses", {29'b0, done, misal, bus_err}, 32'd0);
    rst_n = 1'b1;

    issue(2'd0, 32'h0000_0103, 32'h0000_00AB, 0, 0, 1);
    issue(2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 3, 0, 1);
    issue(2'd2, 32'h0000_01FE, 32'h1122_3344, 0, 0, 1);
    issue(2'd1, 32'h0000_0101, 32'h0000_5566, 1, 0, 1);
    issue(2'd2, 32'h0000_0300, 32'h1234_5678, NEVER, 0, 1);
    issue(2'd1, 32'h0000_0103, 32'hFFFF_A55A, 2, NEVER, 1);
    issue(2'd3, 32'h0000_0040, 32'hCAFE_BABE, 1, 0, 1);
    issue(2'd2, 32'hFFFF_FFFC, 32'h0BAD_F00D, 0, 0, 1);

    for (int r = 0; r < 80; r++) begin
      sel = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      n = (sel == 2'd0) ? 1 : ((sel == 2'd1) ? 2 : 4);
      if ($urandom_range(0, 1) == 0) a = a & ~(32'(n) - 32'd1);
      issue(sel, a, $urandom,
            ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3), 1);
    end

    // Reset in the middle of a beat: wrapped second beat in the split build, a stalled single beat otherwise.
`ifdef STORE_SPLIT_EN
    issue(2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, NEVER, 0);
`else
    issue(2'd2, 32'hFFFF_FFFC, 32'hCAFE_F00D, NEVER, 0, 0);
`endif
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_beats_seen", 32'(exp_beats.size()), 32'd0);
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    check("midrst_be", {28'b0, mem_be}, 32'd0);
    check("midrst_pulses", {29'b0, done, misal, bus_err}, 32'd0);
    exp_beats.delete();
    ack_waits.delete();
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("postrst_quiet", {28'b0, mem_req, done, misal, bus_err}, 32'd0);
    end

    issue(2'd0, 32'h0000_0010, 32'h0000_0077, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
